// File: rtl/demux_pkg.sv
// Shared definitions for the round-robin demux dispatcher.
// Contents: channel count, select width, dispatcher FSM state encoding.
// No logic lives here; imported by the picker and the dispatcher top.
package demux_pkg;

   localparam int NCH   = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask at or above ptr, wrapping 7->0.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: mask (candidate channels), ptr (search start), idx (chosen channel), any (mask != 0).
module rr_pick
   import demux_pkg::*;
(
   input  logic [NCH-1:0]   mask,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic             found;
   logic [SEL_W-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Walk the 8 positions starting at ptr; the 3-bit add wraps naturally.
      for (int i = 0; i < NCH; i++) begin
         cand = ptr + SEL_W'(i);
         if (mask[cand] && !found) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      any = |mask;
   end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher: holds one upstream beat and steers it to an enabled channel.
// Latency: 1 cycle from upstream transfer to out_valid; back-to-back beats with no bubble.
// Backpressure: in_ready drops while the held beat's channel is not ready or no channel is enabled.
// Ports: clk/rst (sync active-high); in_valid/in_data/in_ready upstream; ch_en enable mask;
//        ch_ready per-channel sink ready; out_valid one-hot, out_data shared payload, sel channel
//        index; beat_cnt delivered-beat counter (wraps).
module demux_rr_dispatcher
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [NCH-1:0]    ch_en,
   input  logic [NCH-1:0]    ch_ready,
   output logic [NCH-1:0]    out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  sel,
   output logic [7:0]        beat_cnt
);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] pick_ptr;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             accept;
   logic             xfer;

   // Held beat leaves this cycle; its channel is the only ready bit that matters.
   assign accept = (state == HOLD) && ch_ready[sel];

   // On a simultaneous accept the new beat must see the advanced pointer.
   assign pick_ptr = accept ? (sel + SEL_W'(1)) : ptr;

   rr_pick u_pick (
      .mask (ch_en),
      .ptr  (pick_ptr),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Gated by rst so nothing upstream believes a beat was taken during reset.
   assign in_ready  = !rst && ((state == IDLE) || accept) && pick_any;
   assign xfer      = in_valid && in_ready;
   assign out_valid = (state == HOLD) ? (NCH'(1) << sel) : '0;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (xfer)            state_nxt = HOLD;
         HOLD: if (accept && !xfer) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         sel      <= '0;
         out_data <= '0;
         beat_cnt <= '0;
      end else begin
         if (accept) begin
            ptr      <= sel + SEL_W'(1);
            beat_cnt <= beat_cnt + 8'd1;
         end
         // sel only moves on a transfer, so ch_en changes cannot disturb a held beat.
         if (xfer) begin
            out_data <= in_data;
            sel      <= pick_idx;
         end
      end
   end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench for demux_rr_dispatcher: transaction-level model plus directed literals.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Prints FAIL lines per mismatch and a single summary line.
module tb_demux_rr_dispatcher;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [7:0]        ch_en;
   logic [7:0]        ch_ready;
   logic [7:0]        out_valid;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        sel;
   logic [7:0]        beat_cnt;

   always #5 clk = ~clk;

   demux_rr_dispatcher #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ch_en     (ch_en),
      .ch_ready  (ch_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .beat_cnt  (beat_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A held beat is a (channel, payload) pair; delivery happens when that channel is ready.
   bit       m_held = 0;
   int       m_ch   = 0;
   int       m_dat  = 0;
   int       m_ptr  = 0;
   int       m_cnt  = 0;
   bit       en_cmp = 0;
   int       dut_log_ch[$];
   int       dut_log_dat[$];

   function automatic int first_enabled(input logic [7:0] mask, input int start);
      for (int k = 0; k < 8; k++)
         if (mask[(start + k) % 8]) return (start + k) % 8;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (en_cmp) begin
         bit deliver, take, exp_rdy;
         int nxt_ptr;
         deliver = m_held && ch_ready[m_ch];
         exp_rdy = !rst && (!m_held || deliver) && (ch_en != 8'h00);
         take    = in_valid && exp_rdy;

         chk("in_ready",  32'(in_ready),  32'(exp_rdy));
         chk("out_valid", 32'(out_valid), m_held ? (32'd1 << m_ch) : 32'd0);
         chk("sel",       32'(sel),       32'(m_ch));
         chk("out_data",  32'(out_data),  32'(m_dat));
         chk("beat_cnt",  32'(beat_cnt),  32'(m_cnt));

         if (!rst && (out_valid & ch_ready) != 8'h00) begin
            dut_log_ch.push_back(int'(sel));
            dut_log_dat.push_back(int'(out_data));
         end

         if (rst) begin
            m_held = 0; m_ch = 0; m_dat = 0; m_ptr = 0; m_cnt = 0;
         end else begin
            nxt_ptr = m_ptr;
            if (deliver) begin
               m_cnt   = (m_cnt + 1) % 256;
               nxt_ptr = (m_ch + 1) % 8;
            end
            m_ptr = nxt_ptr;
            if (take) begin
               m_ch   = first_enabled(ch_en, m_ptr);
               m_dat  = int'(in_data);
               m_held = 1;
            end else if (deliver) begin
               m_held = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rr_exp[10];
      int sp_exp[4];
      rr_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
      sp_exp = '{2, 7, 2, 7};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_en = 8'hFF; ch_ready = 8'h00;
      cyc();
      en_cmp = 1'b1;
      cyc();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h00);
      chk("rst_sel",       32'(sel),       32'd0);
      chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      cyc();

      // Round-robin over all channels, back-to-back
      dut_log_ch.delete(); dut_log_dat.delete();
      ch_ready = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h10 + 8'(i);
         @(negedge clk);
         chk("rr_no_bubble", 32'(in_ready), 32'd1);
         cyc();
      end
      in_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      chk("rr_count", 32'(dut_log_ch.size()), 32'd10);
      for (int i = 0; i < 10 && i < dut_log_ch.size(); i++) begin
         chk("rr_sel",  32'(dut_log_ch[i]),  32'(rr_exp[i]));
         chk("rr_data", 32'(dut_log_dat[i]), 32'h10 + 32'(i));
      end
      chk("rr_beat_cnt", 32'(beat_cnt), 32'd10);
      cyc();

      // Sparse mask
      dut_log_ch.delete(); dut_log_dat.delete();
      ch_en = 8'b1000_0100;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      chk("sparse_count", 32'(dut_log_ch.size()), 32'd4);
      for (int i = 0; i < 4 && i < dut_log_ch.size(); i++)
         chk("sparse_sel", 32'(dut_log_ch[i]), 32'(sp_exp[i]));
      cyc();

      // Backpressure on channel 0
      ch_en = 8'hFF; ch_ready = 8'hFE; in_valid = 1'b1; in_data = 8'hA5;
      cyc();
      in_data = 8'h33;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'h01);
         chk("bp_out_data",  32'(out_data),  32'hA5);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         cyc();
      end
      ch_ready = 8'hFF; in_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("bp_delivered_cnt", 32'(beat_cnt),  32'd15);
      chk("bp_idle",          32'(out_valid), 32'h00);
      cyc();

      // Empty mask
      ch_en = 8'h00; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ch_ready = 8'($urandom);
         in_data  = 8'($urandom);
         @(negedge clk);
         chk("empty_in_ready",  32'(in_ready),  32'd0);
         chk("empty_out_valid", 32'(out_valid), 32'h00);
         cyc();
      end

      // Reset while holding a beat on channel 3
      in_valid = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0; ch_en = 8'h08; ch_ready = 8'h00; in_valid = 1'b1; in_data = 8'h5A;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mh_out_valid", 32'(out_valid), 32'h08);
      chk("mh_sel",       32'(sel),       32'd3);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("mh_rst_out_valid", 32'(out_valid), 32'h00);
      chk("mh_rst_beat_cnt",  32'(beat_cnt),  32'd0);
      cyc();
      ch_en = 8'hFF; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h77;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mh_ptr_zero", 32'(sel),       32'd0);
      chk("mh_ptr_ov",   32'(out_valid), 32'h01);
      cyc();

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         ch_ready = 8'($urandom) | ($urandom_range(0, 2) == 0 ? 8'hFF : 8'h00);
         if ($urandom_range(0, 15) == 0)
            ch_en = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0; in_valid = 1'b0;
      cyc();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatcher.md
DEMUX_RR_DISPATCHER -- requirements
Module: demux_rr_dispatcher

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Channel count is fixed at 8, with a 3-bit channel index; it is not a parameter.
REQ-003 Clocking is one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  dispatcher accepts the beat this cycle.
REQ-009 ch_en  input  8  per-channel enable mask (configuration).
REQ-010 ch_ready  input  8  per-channel sink ready.
REQ-011 out_valid  output  8  one-hot valid; the bit at sel is set only while a beat is held.
REQ-012 out_data  output  DATA_W  held payload, shared by all channels.
REQ-013 sel  output  3  channel index of the held beat, i.e. the demux select.
REQ-014 beat_cnt  output  8  count of delivered beats, wraps 255->0.

Function
REQ-015 FSM states: IDLE (no beat held) and HOLD (one beat held in the output register).
REQ-016 in_ready = (state==IDLE | accept) & (ch_en != 0), where accept = (state==HOLD) & ch_ready[sel].
REQ-017 Upstream transfer occurs on an edge where in_valid & in_ready are both 1; it registers in_data into out_data and the picked channel into sel, and the state becomes HOLD.
REQ-018 Pick rule: first channel with ch_en set, searching upward from ptr and wrapping 7->0; ch_en is sampled in the transfer cycle.
REQ-019 Latency: a beat transferred at edge k drives out_valid/out_data from edge k onward, giving 1 cycle.
REQ-020 out_valid = HOLD ? (8'b1 << sel) : 8'h00.
REQ-021 On accept: ptr <= sel+1 mod 8 and beat_cnt <= beat_cnt+1 mod 256.
REQ-022 On accept without a new transfer, the state goes to IDLE. On accept with a simultaneous transfer, the state stays HOLD and the new beat is loaded with no bubble; the pick uses the post-accept ptr.
REQ-023 In HOLD with ch_ready[sel]=0: out_data, sel and out_valid are held stable, and in_ready=0.
REQ-024 ch_en changes while in HOLD do not alter sel or cancel the held beat.
REQ-025 ch_en==0: in_ready=0 and no transfer occurs; a held beat still delivers.
REQ-026 ch_ready bits other than sel are ignored.

Reset
REQ-027 While rst=1 at an edge: state=IDLE, ptr=0, sel=0, out_data=0, beat_cnt=0, out_valid=8'h00, and in_ready=0 in that cycle.
REQ-028 Reset asserted mid-HOLD discards the held beat without counting it.

Structure
REQ-029 Shared package demux_pkg holds: NCH=8, SEL_W=3, the state enum {IDLE, HOLD}.
REQ-030 One sub-module, rr_pick: combinational rotating-priority picker (mask, ptr -> index, any).
REQ-031 Datapath steering is out_valid one-hot from sel; it does not instantiate the combinational demux.

Verification
REQ-032 Reset: rst=1 for 2 cycles, then check out_valid=00, sel=0, beat_cnt=0, and in_ready=1 with ch_en=FF.
REQ-033 Round-robin: ch_en=FF, ch_ready=FF, in_valid=1 for 10 beats with data 0x10..0x19 -> sel sequence 0,1,...,7,0,1; no idle cycles; beat_cnt=10.
REQ-034 Sparse mask: ch_en=8'b1000_0100, 4 beats -> sel 2,7,2,7.
REQ-035 Backpressure: ch_ready[0]=0 for 5 cycles after beat 0xA5 -> out_valid=01, out_data=A5 stable, in_ready=0; release -> delivered, beat_cnt+1.
REQ-036 Empty mask: ch_en=00, in_valid=1 -> in_ready=0 and out_valid=00 for all cycles.
REQ-037 Mid-HOLD reset: beat held on ch 3 with ch_ready=0, rst pulse -> out_valid=00, ptr=0, beat_cnt unchanged from pre-reset value 0.
